neuron_mac_accum: RTL



---
 rtl/neuron_mac_accum.sv | 108 ++++++++++
 1 files changed

// File: rtl/neuron_mac_accum.sv
// Serial signed multiply-accumulate for one neuron: bias + sum(x*w), then
// round-half-up, rescale by FRAC and saturate to DWIDTH bits.
module neuron_mac_accum #(
  parameter int DWIDTH = 16,
  parameter int FRAC   = 8,
  parameter int NINPUT = 4,
  parameter int CWIDTH = 8,
  parameter int ACCW   = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DWIDTH-1:0] bias,
  input  logic signed [DWIDTH-1:0] x,
  input  logic signed [DWIDTH-1:0] w,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     busy,
  output logic signed [DWIDTH-1:0] out,
  output logic                     out_valid,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [ACCW-1:0] MAXV =
    {{(ACCW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV =
    {{(ACCW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (FRAC - 1);

  state_t                     state_q, state_d;
  logic signed [ACCW-1:0]     acc;
  logic [CWIDTH-1:0]          cnt;
  logic signed [2*DWIDTH-1:0] prod;
  logic signed [ACCW-1:0]     prod_ext;
  logic signed [ACCW-1:0]     bias_ext;
  logic signed [ACCW-1:0]     rounded;
  logic signed [DWIDTH-1:0]   sat;
  logic                       last_pair;

  // Handshake: a pair is accepted on a rising edge where in_valid && in_ready;
  // in_ready is a pure function of state, so it never depends on in_valid.
  assign in_ready  = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  assign prod      = x * w;
  assign prod_ext  = {{(ACCW-2*DWIDTH){prod[2*DWIDTH-1]}}, prod};
  assign bias_ext  = {{(ACCW-DWIDTH){bias[DWIDTH-1]}}, bias} <<< FRAC;
  assign last_pair = (cnt == CWIDTH'(NINPUT - 1));

  // Arithmetic shift after adding half an LSB rounds half-up toward +inf.
  assign rounded = (acc + HALF) >>> FRAC;

  always_comb begin
    sat = rounded[DWIDTH-1:0];
    if (rounded > MAXV)      sat = MAXV[DWIDTH-1:0];
    else if (rounded < MINV) sat = MINV[DWIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (in_valid && last_pair) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc <= bias_ext;
            cnt <= '0;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc <= acc + prod_ext;
            cnt <= cnt + CWIDTH'(1);
          end
        end
        DONE: begin
          out       <= sat;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
